mul_seq_unit: RTL and testbench

MUL_SEQ_UNIT -- requirements
Module: mul_seq_unit

---
 rtl/mul_seq_unit.sv | 131 +++++++++++++
 tb/tb_mul_seq_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_seq_unit.sv
// Sequential signed/unsigned multiplier that retires STEP multiplier bits per cycle.
// One request at a time, valid/ready handshake on both sides, flush aborts any operation.
module mul_seq_unit #(
    parameter int WIDTH = 64,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             a_signed,
    input  logic             b_signed,
    input  logic             hi_sel,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);

    localparam int ITERS = WIDTH / STEP;
    localparam int CW    = $clog2(ITERS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0]       mcand;
    logic [2*WIDTH-1:0]     acc;
    logic [CW-1:0]          cnt;
    logic                   neg_q;
    logic                   hi_q;

    logic                   a_neg, b_neg;
    logic [WIDTH-1:0]       in_mag_a, in_mag_b;
    logic                   in_zero;
    logic                   accept;
    logic                   last;
    logic [WIDTH+STEP-1:0]  partial;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     product;
    logic [WIDTH-1:0]       final_half;

    // Unary minus in a WIDTH-bit context makes the most-negative value its own
    // magnitude, 2^(WIDTH-1), which is exact as an unsigned WIDTH-bit number.
    assign a_neg    = a_signed & op_a[WIDTH-1];
    assign b_neg    = b_signed & op_b[WIDTH-1];
    assign in_mag_a = a_neg ? -op_a : op_a;
    assign in_mag_b = b_neg ? -op_b : op_b;
    assign in_zero  = (in_mag_a == '0) | (in_mag_b == '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready & ~flush;
    assign last      = (cnt == CW'(1));

    // acc = {partial high product, remaining multiplier bits}; the low STEP bits
    // are the current multiplier digit and are shifted out each step.
    assign partial  = {{STEP{1'b0}}, mcand} * {{WIDTH{1'b0}}, acc[STEP-1:0]};
    assign acc_step = {{STEP{1'b0}}, acc[2*WIDTH-1:STEP]}
                    + {partial, {(WIDTH-STEP){1'b0}}};

    assign product    = neg_q ? -acc_step : acc_step;
    assign final_half = hi_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets its default before the case, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = in_zero ? DONE : CALC;
            CALC: if (last)      state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            hi_q   <= 1'b0;
            result <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mcand <= in_mag_a;
                        acc   <= {{WIDTH{1'b0}}, in_mag_b};
                        neg_q <= a_neg ^ b_neg;
                        hi_q  <= hi_sel;
                        if (in_zero) begin
                            cnt    <= '0;
                            result <= '0;
                        end else begin
                            cnt <= CW'(ITERS);
                        end
                    end
                end
                CALC: begin
                    acc <= acc_step;
                    cnt <= cnt - CW'(1);
                    if (last) result <= final_half;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed checks of mul_seq_unit at WIDTH=64/STEP=1 and WIDTH=32/STEP=4,
// plus a 32-bit sweep against a 64-bit reference product.
module tb_mul_seq_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        iv64, ir64, as64, bs64, hs64, fl64, ov64, or64;
    logic [63:0] a64, b64, r64;

    logic        iv32, ir32, as32, bs32, hs32, fl32, ov32, or32;
    logic [31:0] a32, b32, r32;

    int n_total = 0;
    int n_bad   = 0;

    mul_seq_unit #(.WIDTH(64), .STEP(1)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .op_a(a64), .op_b(b64), .a_signed(as64), .b_signed(bs64), .hi_sel(hs64),
        .flush(fl64), .out_valid(ov64), .out_ready(or64), .result(r64)
    );

    mul_seq_unit #(.WIDTH(32), .STEP(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .op_a(a32), .op_b(b32), .a_signed(as32), .b_signed(bs32), .hi_sel(hs32),
        .flush(fl32), .out_valid(ov32), .out_ready(or32), .result(r32)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model32(input logic [31:0] a, input logic [31:0] b,
                                            input logic sa, input logic sb, input logic hs);
        logic [63:0] pa, pb, p;
        pa = sa ? {{32{a[31]}}, a} : {32'b0, a};
        pb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        p  = pa * pb;
        return hs ? p[63:32] : p[31:0];
    endfunction

    // Presents one request, scrambles the operand pins after the accept edge and
    // counts rising edges until out_valid is seen (bounded).
    task automatic issue64(input logic [63:0] a, input logic [63:0] b,
                           input logic sa, input logic sb, input logic hs, output int lat);
        @(negedge clk);
        check("rdy64", 64'(ir64), 64'(1));
        a64 = a; b64 = b; as64 = sa; bs64 = sb; hs64 = hs; iv64 = 1'b1;
        @(posedge clk);
        #1;
        iv64 = 1'b0; a64 = ~a; b64 = {$urandom, $urandom}; as64 = ~sa; bs64 = ~sb; hs64 = ~hs;
        lat = 0;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov64) break;
        end
    endtask

    task automatic pop64();
        or64 = 1'b1;
        @(posedge clk);
        #1;
        or64 = 1'b0;
        check("pop64_rdy", 64'(ir64), 64'(1));
        check("pop64_ov", 64'(ov64), 64'(0));
    endtask

    task automatic run64(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb, input logic hs,
                         input logic [63:0] exp, input int exp_lat);
        int lat;
        issue64(a, b, sa, sb, hs, lat);
        check(tag, r64, exp);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        pop64();
    endtask

    task automatic issue32(input logic [31:0] a, input logic [31:0] b,
                           input logic sa, input logic sb, input logic hs, output int lat);
        @(negedge clk);
        check("rdy32", 64'(ir32), 64'(1));
        a32 = a; b32 = b; as32 = sa; bs32 = sb; hs32 = hs; iv32 = 1'b1;
        @(posedge clk);
        #1;
        iv32 = 1'b0; a32 = ~a; b32 = $urandom; as32 = ~sa; bs32 = ~sb; hs32 = ~hs;
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (ov32) break;
        end
    endtask

    task automatic run32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sa, input logic sb, input logic hs,
                         input logic [31:0] exp, input int hold);
        int lat;
        int exp_lat;
        exp_lat = (a == 32'd0 || b == 32'd0) ? 1 : 8;
        issue32(a, b, sa, sb, hs, lat);
        check(tag, 64'(r32), 64'(exp));
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1;
            check({tag, "_hold"}, {31'b0, ov32, r32}, {31'b0, 1'b1, exp});
        end
        or32 = 1'b1;
        @(posedge clk);
        #1;
        or32 = 1'b0;
        check({tag, "_pop"}, 64'(ir32), 64'(1));
    endtask

    initial begin
        int lat;
        int seen;
        logic [31:0] ra, rb;
        logic rsa, rsb, rhs;

        rst_n = 1'b0;
        iv64 = 0; as64 = 0; bs64 = 0; hs64 = 0; fl64 = 0; or64 = 0; a64 = '0; b64 = '0;
        iv32 = 0; as32 = 0; bs32 = 0; hs32 = 0; fl32 = 0; or32 = 0; a32 = '0; b32 = '0;
        #12;
        check("rst_rdy64", 64'(ir64), 64'(1));
        check("rst_ov64", 64'(ov64), 64'(0));
        check("rst_res64", r64, 64'(0));
        check("rst_rdy32", 64'(ir32), 64'(1));
        check("rst_res32", 64'(r32), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run64("u3x5", 64'd3, 64'd5, 0, 0, 0, 64'd15, 64);
        run64("ss_m1_lo", '1, '1, 1, 1, 0, 64'd1, 64);
        run64("ss_m1_hi", '1, '1, 1, 1, 1, 64'd0, 64);
        run64("su_m1_hi", '1, '1, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run64("uu_m1_hi", '1, '1, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run64("min_hi", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 1,
              64'h4000_0000_0000_0000, 64);
        run64("min_lo", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1, 1, 0,
              64'd0, 64);
        run64("n3x5_lo", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF1, 64);
        run64("n3x5_hi", 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64);
        run64("b_zero", 64'd5, 64'd0, 1, 1, 0, 64'd0, 1);

        // Zero operand: immediate DONE, then held while the consumer stalls.
        issue64(64'd0, 64'd7, 0, 0, 0, lat);
        check("zero_lat", 64'(lat), 64'(1));
        check("zero_res", r64, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("stall_ov", 64'(ov64), 64'(1));
        check("stall_res", r64, 64'd0);
        check("stall_rdy", 64'(ir64), 64'(0));
        pop64();

        // Flush mid-CALC, sampled on the 20th edge after accept.
        @(negedge clk);
        a64 = 64'd3; b64 = 64'd5; as64 = 0; bs64 = 0; hs64 = 0; iv64 = 1'b1;
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        fl64 = 1'b1;
        @(posedge clk);
        #1;
        fl64 = 1'b0;
        check("flush_rdy", 64'(ir64), 64'(1));
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (ov64) seen++;
        end
        check("flush_no_valid", 64'(seen), 64'(0));

        // Flush wins over a simultaneous request in IDLE.
        @(negedge clk);
        a64 = 64'd3; b64 = 64'd5; iv64 = 1'b1; fl64 = 1'b1;
        @(posedge clk);
        #1;
        iv64 = 1'b0; fl64 = 1'b0;
        check("flush_vs_accept", 64'(ir64), 64'(1));

        // Flush wins over out_ready in DONE; the result register keeps its value.
        issue64(64'd0, 64'd9, 0, 0, 0, lat);
        fl64 = 1'b1;
        @(posedge clk);
        #1;
        fl64 = 1'b0;
        check("flush_done_ov", 64'(ov64), 64'(0));
        check("flush_done_rdy", 64'(ir64), 64'(1));

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        a64 = '1; b64 = '1; as64 = 0; bs64 = 0; hs64 = 1; iv64 = 1'b1;
        @(posedge clk);
        #1;
        iv64 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 64'(ir64), 64'(1));
        check("arst_ov", 64'(ov64), 64'(0));
        check("arst_res", r64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (ov64) seen++;
        end
        check("arst_no_valid", 64'(seen), 64'(0));
        run64("post_rst_3x5", 64'd3, 64'd5, 0, 0, 0, 64'd15, 64);

        // 32-bit, 4 bits per cycle.
        run32("w32_7x6", 32'd7, 32'd6, 0, 0, 0, 32'd42, 0);
        run32("w32_min_hi", 32'h8000_0000, 32'h8000_0000, 1, 1, 1, 32'h4000_0000, 2);
        run32("w32_m1_su_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 1, 32'hFFFF_FFFF, 0);
        run32("w32_uu_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 1, 32'hFFFF_FFFE, 0);

        for (int i = 0; i < 2000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 9) == 0) ra = 32'd0;
            if ($urandom_range(0, 9) == 0) rb = 32'd0;
            rsa = 1'($urandom_range(0, 1));
            rsb = 1'($urandom_range(0, 1));
            rhs = 1'($urandom_range(0, 1));
            run32("w32_rand", ra, rb, rsa, rsb, rhs, model32(ra, rb, rsa, rsb, rhs),
                  int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
